// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//   WIDTH-bit bitwise logic unit with runtime op select, optional accumulate
//   mode and result flags, built as a two-stage valid/ready pipeline.
//   A beat presented in the cycle before edge E is captured in stage 1 at E
//   and is visible on the out_* ports after edge E+1 when nothing stalls.
//
// Optional feature macro: LOGIC_UNIT_CNT_EN
//   defined   -> out_count counts output transfers, saturating at all ones
//   undefined -> no counter register, out_count tied to 0
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : input beat valid
//   in_ready   : unit can accept a beat this cycle
//   in_op      : op select (000 AND, 001 OR, 010 NOT A, 011 NAND,
//                100 NOR, 101 XOR, 110 XNOR, 111 PASS A)
//   in_a       : operand A (replaced by the accumulator when in_acc_en=1)
//   in_b       : operand B
//   in_acc_en  : use accumulator as A and write the result back to it
//   acc_clr    : synchronous accumulator clear, independent of handshake
//   out_valid  : output beat valid
//   out_ready  : consumer accepts the output beat
//   out_data   : result
//   out_zero   : result == 0
//   out_ones   : result == all ones
//   out_parity : XOR reduction of result (1 = odd number of ones)
//   acc_value  : registered accumulator contents
//   out_count  : completed output transfers (optional feature)
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic [WIDTH-1:0] acc_value,
  output logic [CNT_W-1:0] out_count
);

  // Bitwise operation selected by op; purely per-bit, no carries.
  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = ~a;
      3'b011:  r = ~(a & b);
      3'b100:  r = ~(a | b);
      3'b101:  r = a ^ b;
      3'b110:  r = ~(a ^ b);
      3'b111:  r = a;
      default: r = a;
    endcase
    return r;
  endfunction

  // Even/odd parity helper: 1 when v holds an odd number of ones.
  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q,  s2_data_d;
  logic             s2_zero_q,  s2_zero_d;
  logic             s2_ones_q,  s2_ones_d;
  logic             s2_par_q,   s2_par_d;
  logic [WIDTH-1:0] acc_q,      acc_d;

  logic             s2_adv;
  logic             s1_adv;
  logic             in_xfer;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_res;

  // A stage may load when it is empty or its content moves on this edge.
  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;
  assign in_xfer  = in_valid & s1_adv;

  // The accumulator is read before any clear lands, so a colliding beat
  // still sees the pre-clear value.
  assign op_a   = in_acc_en ? acc_q : in_a;
  assign op_res = logic_op(in_op, op_a, in_b);

  // Next-state logic for both pipeline stages and the accumulator.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_zero_d  = s2_zero_q;
    s2_ones_d  = s2_ones_q;
    s2_par_d   = s2_par_q;
    acc_d      = acc_q;

    if (s1_adv) begin
      s1_valid_d = in_xfer;
      if (in_xfer) begin
        s1_data_d = op_res;
      end else begin
        s1_data_d = s1_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s1_data_q;
        s2_zero_d = (s1_data_q == {WIDTH{1'b0}});
        s2_ones_d = &s1_data_q;
        s2_par_d  = parity_of(s1_data_q);
      end else begin
        s2_data_d = s2_data_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end

    // Clear wins over a same-edge accumulate write.
    if (acc_clr) begin
      acc_d = {WIDTH{1'b0}};
    end else if (in_xfer && in_acc_en) begin
      acc_d = op_res;
    end else begin
      acc_d = acc_q;
    end
  end

  // Pipeline and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= {WIDTH{1'b0}};
      s2_valid_q <= 1'b0;
      s2_data_q  <= {WIDTH{1'b0}};
      s2_zero_q  <= 1'b0;
      s2_ones_q  <= 1'b0;
      s2_par_q   <= 1'b0;
      acc_q      <= {WIDTH{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_zero_q  <= s2_zero_d;
      s2_ones_q  <= s2_ones_d;
      s2_par_q   <= s2_par_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_data   = s2_data_q;
  assign out_zero   = s2_zero_q;
  assign out_ones   = s2_ones_q;
  assign out_parity = s2_par_q;
  assign acc_value  = acc_q;

`ifdef LOGIC_UNIT_CNT_EN
  logic             out_xfer;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign out_xfer = s2_valid_q & out_ready;

  // Saturating count of output transfers.
  always_comb begin
    cnt_d = cnt_q;
    if (out_xfer && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output transfer counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_count = cnt_q;
`else
  assign out_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// Bench for logic_unit_pipe (WIDTH=8, CNT_W=16).
// A transaction-level model (queue of in-flight results with their age in
// edges, per-bit truth tables for the ops) is compared every negedge against
// the DUT; directed literal checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_acc_en;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_zero;
  logic        out_ones;
  logic        out_parity;
  logic [7:0]  acc_value;
  logic [15:0] out_count;

  int n_chk;
  int n_fail;

  logic [7:0] exp_q[$];
  int         age_q[$];
  logic [7:0] acc_m;
  int         cnt_m;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_acc_en(in_acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity),
    .acc_value(acc_value), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each op as a truth table indexed by {a_bit, b_bit}.
  function automatic logic [7:0] model_op(input logic [2:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    logic [3:0] tt;
    logic [7:0] r;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0011;
      3'd3:    tt = 4'b0111;
      3'd4:    tt = 4'b0001;
      3'd5:    tt = 4'b0110;
      3'd6:    tt = 4'b1001;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: beats enter with age 1; the oldest beat is visible once age >= 2.
  always @(posedge clk or posedge rst) begin
    logic       ov_m;
    logic       ir_m;
    logic [7:0] opa;
    logic [7:0] r;
    if (rst) begin
      exp_q.delete();
      age_q.delete();
      acc_m = 8'h00;
      cnt_m = 0;
    end else begin
      ov_m = (exp_q.size() > 0) && (age_q[0] >= 2);
      ir_m = (exp_q.size() < 2) || out_ready;
      if (ov_m && out_ready) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
        if (cnt_m < 65535) cnt_m = cnt_m + 1;
      end
      for (int i = 0; i < age_q.size(); i++) age_q[i] = age_q[i] + 1;
      if (in_valid && ir_m) begin
        opa = in_acc_en ? acc_m : in_a;
        r   = model_op(in_op, opa, in_b);
        exp_q.push_back(r);
        age_q.push_back(1);
        if (in_acc_en) acc_m = r;
      end
      if (acc_clr) acc_m = 8'h00;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic       ov_m;
    logic       ir_m;
    logic [7:0] d;
    ov_m = (exp_q.size() > 0) && (age_q[0] >= 2);
    ir_m = (exp_q.size() < 2) || out_ready;
    chk("m_in_ready", {15'd0, in_ready}, {15'd0, ir_m});
    chk("m_out_valid", {15'd0, out_valid}, {15'd0, ov_m});
    chk("m_acc_value", {8'd0, acc_value}, {8'd0, acc_m});
`ifdef LOGIC_UNIT_CNT_EN
    chk("m_out_count", out_count, cnt_m[15:0]);
`else
    chk("m_out_count", out_count, 16'd0);
`endif
    if (ov_m) begin
      d = exp_q[0];
      chk("m_out_data", {8'd0, out_data}, {8'd0, d});
      chk("m_out_zero", {15'd0, out_zero}, {15'd0, (d == 8'h00)});
      chk("m_out_ones", {15'd0, out_ones}, {15'd0, (d == 8'hFF)});
      chk("m_out_parity", {15'd0, out_parity}, {15'd0, ($countones(d) % 2 == 1)});
    end
  end

  // Drive one cycle of inputs starting at posedge+2.
  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic acc_en, input logic clr);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_acc_en = acc_en;
    acc_clr   = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    acc_clr   = 1'b0;
    in_acc_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_acc_en = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_acc", {8'd0, acc_value}, 16'd0);
    chk("rst_count", out_count, 16'd0);
    chk("rst_out_data", {8'd0, out_data}, 16'd0);
    idle(1);
    rst = 1'b0;

    // AND / XOR on F0, 3C
    drive(3'b000, 8'hF0, 8'h3C, 1'b0, 1'b0);
    idle(1);
    chk("and_data", {8'd0, out_data}, 16'h0030);
    chk("and_zero", {15'd0, out_zero}, 16'd0);
    chk("and_ones", {15'd0, out_ones}, 16'd0);
    chk("and_parity", {15'd0, out_parity}, 16'd0);
    drive(3'b101, 8'hF0, 8'h3C, 1'b0, 1'b0);
    idle(1);
    chk("xor_data", {8'd0, out_data}, 16'h00CC);
    chk("xor_parity", {15'd0, out_parity}, 16'd0);

    // NAND / OR / NOT
    drive(3'b011, 8'hFF, 8'hFF, 1'b0, 1'b0);
    idle(1);
    chk("nand_data", {8'd0, out_data}, 16'h0000);
    chk("nand_zero", {15'd0, out_zero}, 16'd1);
    drive(3'b001, 8'h0F, 8'hF0, 1'b0, 1'b0);
    idle(1);
    chk("or_data", {8'd0, out_data}, 16'h00FF);
    chk("or_ones", {15'd0, out_ones}, 16'd1);
    chk("or_parity", {15'd0, out_parity}, 16'd0);
    drive(3'b010, 8'hA5, 8'h77, 1'b0, 1'b0);
    idle(1);
    chk("not_data", {8'd0, out_data}, 16'h005A);

    // Accumulate chain: in_a carries junk that must be ignored
    in_valid = 1'b0;
    acc_clr  = 1'b1;
    @(posedge clk);
    #2;
    drive(3'b001, 8'hAA, 8'h01, 1'b1, 1'b0);
    drive(3'b001, 8'hAA, 8'h02, 1'b1, 1'b0);
    drive(3'b001, 8'hAA, 8'h04, 1'b1, 1'b0);
    chk("acc_chain_value", {8'd0, acc_value}, 16'h0007);
    chk("acc_chain_mid", {8'd0, out_data}, 16'h0003);
    idle(1);
    chk("acc_chain_last", {8'd0, out_data}, 16'h0007);
    chk("acc_chain_parity", {15'd0, out_parity}, 16'd1);

    // Clear collides with an accumulate beat
    drive(3'b101, 8'h00, 8'hFF, 1'b1, 1'b1);
    chk("clr_coll_acc", {8'd0, acc_value}, 16'h0000);
    idle(1);
    chk("clr_coll_data", {8'd0, out_data}, 16'h00F8);
    idle(2);

    // Backpressure: two beats fill the pipe, third is held
    out_ready = 1'b0;
    drive(3'b000, 8'hFF, 8'h11, 1'b0, 1'b0);
    drive(3'b000, 8'hFF, 8'h22, 1'b0, 1'b0);
    chk("bp_full_ready", {15'd0, in_ready}, 16'd0);
    drive(3'b000, 8'hFF, 8'h33, 1'b0, 1'b0);
    chk("bp_hold_ready", {15'd0, in_ready}, 16'd0);
    chk("bp_hold_data", {8'd0, out_data}, 16'h0011);
    chk("bp_hold_valid", {15'd0, out_valid}, 16'd1);
    drive(3'b000, 8'hFF, 8'h33, 1'b0, 1'b0);
    chk("bp_stable_data", {8'd0, out_data}, 16'h0011);
    out_ready = 1'b1;
    drive(3'b000, 8'hFF, 8'h33, 1'b0, 1'b0);
    chk("bp_second", {8'd0, out_data}, 16'h0022);
    idle(1);
    chk("bp_third", {8'd0, out_data}, 16'h0033);
    idle(1);
    chk("bp_drained", {15'd0, out_valid}, 16'd0);
`ifdef LOGIC_UNIT_CNT_EN
    chk("bp_count", out_count, 16'd12);
`else
    chk("bp_count", out_count, 16'd0);
`endif

    // Reset with both stages full and a non-zero accumulator
    out_ready = 1'b0;
    drive(3'b001, 8'h00, 8'h5A, 1'b1, 1'b0);
    drive(3'b000, 8'hFF, 8'h11, 1'b0, 1'b0);
    chk("pre_rst_acc", {8'd0, acc_value}, 16'h005A);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_mid_acc", {8'd0, acc_value}, 16'd0);
    chk("rst_mid_count", out_count, 16'd0);
    chk("rst_mid_ready", {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_ready", {15'd0, in_ready}, 16'd1);
    drive(3'b101, 8'h0F, 8'hFF, 1'b0, 1'b0);
    chk("post_rst_lat1", {15'd0, out_valid}, 16'd0);
    idle(1);
    chk("post_rst_lat2", {15'd0, out_valid}, 16'd1);
    chk("post_rst_data", {8'd0, out_data}, 16'h00F0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
